// File: rtl/ladybird_config.sv
// ladybird_config: shared ladybird widths, instruction constructors and progbuf state encoding
package ladybird_config;
  localparam int XLEN = 32;
  localparam int PROGBUF_DEPTH = 8;
  typedef enum logic [1:0] {PB_IDLE, PB_ISSUE, PB_TAIL, PB_FIN} progbuf_state_e;
  function automatic logic [31:0] NOP();
    return 32'h0000_0013;
  endfunction
  function automatic logic [31:0] EBREAK();
    return 32'h0010_0073;
  endfunction
  function automatic logic [31:0] ADDI(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] ADD(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
endpackage

// File: rtl/ladybird_progbuf.sv
// ladybird_progbuf: debug program buffer replaying stored words followed by an implicit EBREAK
module ladybird_progbuf #(
  parameter int DEPTH = ladybird_config::PROGBUF_DEPTH,
  parameter int XLEN = ladybird_config::XLEN
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       wr_valid,
  input  logic [$clog2(DEPTH)-1:0]   wr_index,
  input  logic [XLEN-1:0]            wr_data,
  input  logic                       go,
  input  logic [$clog2(DEPTH):0]     go_len,
  input  logic                       abort,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [XLEN-1:0]            inst,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted
);
  import ladybird_config::*;
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  progbuf_state_e state;
  logic [IW-1:0] ptr;
  logic [LW-1:0] len;
  logic [LW-1:0] go_len_c;
  logic [XLEN-1:0] mem [DEPTH];
  logic hs;
  logic last;
  assign go_len_c = (go_len > LW'(DEPTH)) ? LW'(DEPTH) : go_len;
  assign hs = inst_valid & inst_ready;
  assign last = {1'b0, ptr} == len - LW'(1);
  assign inst_valid = (state == PB_ISSUE) || (state == PB_TAIL);
  assign inst = (state == PB_ISSUE) ? mem[ptr] : (state == PB_TAIL) ? EBREAK() : NOP();
  assign busy = state != PB_IDLE;
  assign done = state == PB_FIN;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= PB_IDLE;
      ptr <= '0;
      len <= '0;
      aborted <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP();
    end else begin
      aborted <= 1'b0;
      case (state)
        PB_IDLE: begin
          if (wr_valid && int'(wr_index) < DEPTH) mem[wr_index] <= wr_data;
          if (go) begin
            len <= go_len_c;
            ptr <= '0;
            state <= (go_len_c == '0) ? PB_TAIL : PB_ISSUE;
          end
        end
        PB_ISSUE: begin
          // abort wins over a handshake landing in the same cycle
          if (abort) begin
            state <= PB_IDLE;
            aborted <= 1'b1;
          end else if (hs) begin
            ptr <= ptr + IW'(1);
            if (last) state <= PB_TAIL;
          end
        end
        PB_TAIL: begin
          if (abort) begin
            state <= PB_IDLE;
            aborted <= 1'b1;
          end else if (hs) state <= PB_FIN;
        end
        default: state <= PB_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ladybird_progbuf.md
LADYBIRD_PROGBUF -- requirements
Module: ladybird_progbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of program-buffer entries (legal 2..16).
REQ-002 SHALL have parameter XLEN, default ladybird_config::XLEN, instruction width (32 only).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  write strobe for one buffer entry.
REQ-006 SHALL have port wr_index  input  $clog2(DEPTH)  entry index to write.
REQ-007 SHALL have port wr_data  input  XLEN  instruction word to store.
REQ-008 SHALL have port go  input  1  start-execution pulse.
REQ-009 SHALL have port go_len  input  $clog2(DEPTH)+1  number of entries to issue (0..DEPTH).
REQ-010 SHALL have port abort  input  1  cancel the running sequence.
REQ-011 SHALL have port inst_valid  output  1  instruction offered to core.
REQ-012 SHALL have port inst_ready  input  1  core accepts instruction.
REQ-013 SHALL have port inst  output  XLEN  offered instruction word.
REQ-014 SHALL have port busy  output  1  sequence in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-016 SHALL have port aborted  output  1  one-cycle pulse when abort cancels a running sequence.

Function
REQ-017 SHALL implement states IDLE, ISSUE, TAIL (implicit EBREAK) and FIN (done pulse).
REQ-018 SHALL, in IDLE, write wr_data to entry wr_index when wr_valid is high; writes SHALL be ignored in every other state.
REQ-019 SHALL, on go in IDLE, latch min(go_len, DEPTH) and zero the issue pointer; ISSUE is entered when length >0, TAIL when length =0.
REQ-020 SHALL ignore go outside IDLE.
REQ-021 SHALL, in ISSUE, drive inst_valid=1 and inst=entry[pointer]; inst and inst_valid SHALL remain stable until handshake (inst_valid & inst_ready).
REQ-022 SHALL advance the pointer on each handshake; the handshake of entry length-1 SHALL move to TAIL the next cycle.
REQ-023 SHALL, in TAIL, offer EBREAK (32'h0010_0073) with inst_valid=1; its handshake SHALL move to FIN.
REQ-024 SHALL, in FIN, assert done for exactly one cycle, then return to IDLE.
REQ-025 SHALL assert busy in ISSUE, TAIL and FIN; deassert in IDLE.
REQ-026 SHALL, on abort in ISSUE or TAIL, go to IDLE next cycle, drop inst_valid, pulse aborted for one cycle, and suppress done; abort taking priority over a same-cycle handshake.
REQ-027 SHALL ignore abort in IDLE and FIN (no aborted pulse).
REQ-028 SHALL give go-to-first-inst_valid latency of one cycle; handshake-to-next inst_valid zero cycles (back-to-back, one instruction per cycle with inst_ready held high).
REQ-029 SHALL drive inst = NOP (32'h0000_0013) whenever inst_valid=0.
REQ-030 SHALL not modify buffer contents during or after a sequence; reissue with a second go replays identical words.

Reset
REQ-031 SHALL, on nrst low, enter IDLE asynchronously; inst_valid, busy, done, aborted =0; pointer and length =0.
REQ-032 SHALL initialise every buffer entry to NOP (ADDI x0,x0,0) on reset.
REQ-033 SHALL, on reset mid-sequence, discard the sequence without done or aborted pulse.

Structure
REQ-034 SHALL add to ladybird_config: EBREAK() constructor, PROGBUF_DEPTH default constant (8), progbuf state enum typedef; NOP() reused.
REQ-035 SHALL be a single module with no sub-modules; buffer as a flop array (reset-initialised).

Verification
REQ-036 SHALL cover: write entries 0..2 = ADDI(1,0,5), ADDI(2,1,3), ADD(3,1,2), go_len=3, inst_ready=1 -> four consecutive words 0x00500093, 0x00308113, 0x002081B3, 0x00100073, then done one cycle later.
REQ-037 SHALL cover: go_len=0 -> only EBREAK issued, done pulse, busy high exactly 2 cycles beyond go.
REQ-038 SHALL cover: inst_ready held low 5 cycles on entry 1 -> inst stable at entry-1 word for all 5 cycles; no skip, no duplicate.
REQ-039 SHALL cover: abort during entry 1 with inst_ready=1 same cycle -> inst_valid=0 next cycle, aborted pulse, no done, go then replays from entry 0.
REQ-040 SHALL cover: wr_valid and go during busy -> buffer unchanged, sequence unaffected; reset mid-sequence -> all outputs 0, entries read back as 0x00000013.
